// File: rtl/arrow_judge_pkg.sv
// Shared codes for the rhythm game: play states, display arrow codes and the
// mask-to-arrow encoder used by the input judge.
package arrow_judge_pkg;

  localparam int unsigned STATE_BITS = 2;
  localparam logic [STATE_BITS-1:0] STATE_GAME  = 2'd0;
  localparam logic [STATE_BITS-1:0] STATE_PAUSE = 2'd1;
  localparam logic [STATE_BITS-1:0] STATE_RESET = 2'd2;

  localparam int unsigned ARROW_BITS = 5;
  localparam logic [ARROW_BITS-1:0] ARROW_UP      = 5'd10;
  localparam logic [ARROW_BITS-1:0] ARROW_DOWN    = 5'd11;
  localparam logic [ARROW_BITS-1:0] ARROW_LEFT    = 5'd12;
  localparam logic [ARROW_BITS-1:0] ARROW_RIGHT   = 5'd13;
  localparam logic [ARROW_BITS-1:0] ARROW_UD      = 5'd14;
  localparam logic [ARROW_BITS-1:0] ARROW_UL      = 5'd15;
  localparam logic [ARROW_BITS-1:0] ARROW_UR      = 5'd16;
  localparam logic [ARROW_BITS-1:0] ARROW_DL      = 5'd17;
  localparam logic [ARROW_BITS-1:0] ARROW_DR      = 5'd18;
  localparam logic [ARROW_BITS-1:0] ARROW_LR      = 5'd19;
  localparam logic [ARROW_BITS-1:0] ARROW_NONE    = 5'd20;
  localparam logic [ARROW_BITS-1:0] ARROW_INVALID = 5'd21;

  localparam int unsigned SCORE_MAX  = 9999;
  localparam int unsigned SCORE_BITS = 14;

  // Button mask bit order: [3]=up, [2]=down, [1]=left, [0]=right.
  typedef logic [3:0] arrow_mask_t;

  function automatic logic [ARROW_BITS-1:0] mask_to_code(input arrow_mask_t mask);
    logic [ARROW_BITS-1:0] code;
    case (mask)
      4'b0000: code = ARROW_NONE;
      4'b1000: code = ARROW_UP;
      4'b0100: code = ARROW_DOWN;
      4'b0010: code = ARROW_LEFT;
      4'b0001: code = ARROW_RIGHT;
      4'b1100: code = ARROW_UD;
      4'b1010: code = ARROW_UL;
      4'b1001: code = ARROW_UR;
      4'b0110: code = ARROW_DL;
      4'b0101: code = ARROW_DR;
      4'b0011: code = ARROW_LR;
      default: code = ARROW_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/arrow_judge_button_debouncer.sv
// Single-button synchronizer and debouncer; emits a one-cycle pulse when the
// accepted level goes high.
module button_debouncer
  import arrow_judge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_BITS         = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0]         sync_q;
  logic               db_q, db_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;
  logic               rise_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == DB_BITS'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= db_d & ~db_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/arrow_judge.sv
// Beat-window input judge: collects debounced arrow presses per metronome beat
// and scores them against the arrow shown in the hit slot.
module arrow_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_BITS         = 16,
  parameter int unsigned SCORE_MAX       = arrow_judge_pkg::SCORE_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        metronome_clk,
  input  logic [1:0]  state,
  input  logic [4:0]  target_arrow,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [4:0]  pressed_arrow,
  output logic        hit,
  output logic        miss,
  output logic [13:0] score,
  output logic [13:0] combo_count
);
  import arrow_judge_pkg::*;

  localparam logic [SCORE_BITS-1:0] ScoreSat = SCORE_BITS'(SCORE_MAX);

  logic [2:0]  met_sync_q;
  logic        beat_q;
  arrow_mask_t btn_raw, rise;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_BITS        (DB_BITS)
    ) u_db (
      .clk_i (clk),
      .rst_ni(rst_n),
      .btn_i (btn_raw[i]),
      .rise_o(rise[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      met_sync_q <= '0;
      beat_q     <= 1'b0;
    end else begin
      met_sync_q <= {met_sync_q[1:0], metronome_clk};
      beat_q     <= met_sync_q[1] & ~met_sync_q[2];
    end
  end

  arrow_mask_t           mask_q, mask_d;
  logic [ARROW_BITS-1:0] target_q, target_d, pressed_q, pressed_d, code;
  logic                  hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_BITS-1:0] score_q, score_d, combo_q, combo_d;

  assign code = mask_to_code(mask_q);

  always_comb begin
    mask_d    = mask_q;
    target_d  = target_q;
    pressed_d = pressed_q;
    score_d   = score_q;
    combo_d   = combo_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    case (state)
      STATE_GAME: begin
        if (beat_q) begin
          // A press landing on the beat cycle opens the new window.
          mask_d    = rise;
          target_d  = target_arrow;
          pressed_d = code;
          if (target_q == ARROW_NONE && mask_q == '0) begin
            hit_d = 1'b0;
          end else if (target_q != ARROW_NONE && code != ARROW_INVALID && code == target_q) begin
            hit_d   = 1'b1;
            score_d = (score_q >= ScoreSat) ? score_q : score_q + SCORE_BITS'(1);
            combo_d = (combo_q >= ScoreSat) ? combo_q : combo_q + SCORE_BITS'(1);
          end else begin
            miss_d  = 1'b1;
            combo_d = '0;
          end
        end else begin
          mask_d = mask_q | rise;
        end
      end
      STATE_RESET: begin
        mask_d    = '0;
        target_d  = ARROW_NONE;
        pressed_d = ARROW_NONE;
        score_d   = '0;
        combo_d   = '0;
      end
      default: begin
        mask_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= '0;
      target_q  <= ARROW_NONE;
      pressed_q <= ARROW_NONE;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      score_q   <= '0;
      combo_q   <= '0;
    end else begin
      mask_q    <= mask_d;
      target_q  <= target_d;
      pressed_q <= pressed_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
    end
  end

  assign pressed_arrow = pressed_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign score         = score_q;
  assign combo_count   = combo_q;

endmodule

// File: tb/tb_arrow_judge.sv
// Directed bench for arrow_judge: table of beat windows plus hand sequences for
// bounce, pause, state reset and rst_n during a beat.
module tb_arrow_judge;

  localparam int unsigned DbCycles = 8;
  localparam int unsigned ScoreMax = 6;
  localparam int unsigned Hold     = 3 * DbCycles;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        metronome_clk = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [4:0]  target_arrow = 5'd20;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [4:0]  pressed_arrow;
  logic        hit, miss;
  logic [13:0] score, combo_count;

  arrow_judge #(
    .DEBOUNCE_CYCLES(DbCycles),
    .DB_BITS        (16),
    .SCORE_MAX      (ScoreMax)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .metronome_clk(metronome_clk),
    .state        (state),
    .target_arrow (target_arrow),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .pressed_arrow(pressed_arrow),
    .hit          (hit),
    .miss         (miss),
    .score        (score),
    .combo_count  (combo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int hit_seen = 0, miss_seen = 0, overlap = 0;

  always @(negedge clk) begin
    if (hit) hit_seen++;
    if (miss) miss_seen++;
    if (hit && miss) overlap++;
  end

  typedef struct {
    logic [4:0] tgt;    // target judged in this window
    logic [3:0] btns;   // {up, down, left, right} pressed in this window
    logic [4:0] code;
    int         hits;
    int         misses;
    int         score;
    int         combo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      3: btn_up = v;
      2: btn_down = v;
      1: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press(input logic [3:0] m);
    for (int b = 3; b >= 0; b--) begin
      if (m[b]) begin
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (5) @(negedge clk);
      end
    end
    repeat (Hold) @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (Hold) @(negedge clk);
  endtask

  // One metronome period; returns hit/miss pulse cycles seen during it.
  task automatic beat(output int dh, output int dm);
    int h0, m0;
    @(negedge clk);
    h0 = hit_seen;
    m0 = miss_seen;
    metronome_clk = 1'b1;
    repeat (12) @(negedge clk);
    metronome_clk = 1'b0;
    repeat (12) @(negedge clk);
    dh = hit_seen - h0;
    dm = miss_seen - m0;
  endtask

  initial begin
    int dh, dm;
    vecs[0]  = '{5'd10, 4'b1000, 5'd10, 1, 0, 1, 1};
    vecs[1]  = '{5'd16, 4'b1001, 5'd16, 1, 0, 2, 2};
    vecs[2]  = '{5'd16, 4'b1110, 5'd21, 0, 1, 2, 0};
    vecs[3]  = '{5'd13, 4'b0001, 5'd13, 1, 0, 3, 1};
    vecs[4]  = '{5'd14, 4'b0000, 5'd20, 0, 1, 3, 0};
    vecs[5]  = '{5'd17, 4'b0110, 5'd17, 1, 0, 4, 1};
    vecs[6]  = '{5'd18, 4'b0101, 5'd18, 1, 0, 5, 2};
    vecs[7]  = '{5'd19, 4'b0011, 5'd19, 1, 0, 6, 3};
    vecs[8]  = '{5'd11, 4'b0100, 5'd11, 1, 0, 6, 4};
    vecs[9]  = '{5'd15, 4'b1010, 5'd15, 1, 0, 6, 5};
    vecs[10] = '{5'd12, 4'b0010, 5'd12, 1, 0, 6, 6};
    vecs[11] = '{5'd12, 4'b0010, 5'd12, 1, 0, 6, 6};
    vecs[12] = '{5'd20, 4'b1000, 5'd10, 0, 1, 6, 0};
    vecs[13] = '{5'd20, 4'b0000, 5'd20, 0, 0, 6, 0};

    repeat (4) @(negedge clk);
    check("rst score", int'(score), 0);
    check("rst combo", int'(combo_count), 0);
    check("rst pressed", int'(pressed_arrow), 20);
    check("rst hit", int'(hit), 0);
    check("rst miss", int'(miss), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Window target is NONE after reset: empty first beat is neutral.
    target_arrow = vecs[0].tgt;
    beat(dh, dm);
    check("first hit", dh, 0);
    check("first miss", dm, 0);
    check("first score", int'(score), 0);
    check("first pressed", int'(pressed_arrow), 20);

    for (int i = 0; i < 14; i++) begin
      press(vecs[i].btns);
      target_arrow = (i < 13) ? vecs[i+1].tgt : 5'd12;
      beat(dh, dm);
      check($sformatf("v%0d code", i), int'(pressed_arrow), int'(vecs[i].code));
      check($sformatf("v%0d hit", i), dh, vecs[i].hits);
      check($sformatf("v%0d miss", i), dm, vecs[i].misses);
      check($sformatf("v%0d score", i), int'(score), vecs[i].score);
      check($sformatf("v%0d combo", i), int'(combo_count), vecs[i].combo);
    end

    // Left bounces faster than the debounce window: no rise, target 12 missed.
    for (int t = 0; t < 10; t++) begin
      btn_left = ~btn_left;
      repeat (3) @(negedge clk);
    end
    btn_left = 1'b0;
    repeat (Hold) @(negedge clk);
    target_arrow = 5'd10;
    beat(dh, dm);
    check("bounce miss", dm, 1);
    check("bounce hit", dh, 0);
    check("bounce pressed", int'(pressed_arrow), 20);
    check("bounce score", int'(score), 6);

    // Press registered in GAME, then PAUSE clears the pending window.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (Hold) @(negedge clk);
    state = 2'd1;
    btn_up = 1'b0;
    repeat (Hold) @(negedge clk);
    state = 2'd3;
    beat(dh, dm);
    check("pause hit", dh, 0);
    check("pause miss", dm, 0);
    check("pause score", int'(score), 6);
    state = 2'd0;
    beat(dh, dm);
    check("resume miss", dm, 1);
    check("resume pressed", int'(pressed_arrow), 20);

    press(4'b1000);
    beat(dh, dm);
    check("sat hit", dh, 1);
    check("sat score", int'(score), 6);
    check("sat combo", int'(combo_count), 1);

    @(negedge clk);
    state = 2'd2;
    @(negedge clk);
    state = 2'd0;
    @(negedge clk);
    check("sreset score", int'(score), 0);
    check("sreset combo", int'(combo_count), 0);
    check("sreset pressed", int'(pressed_arrow), 20);
    beat(dh, dm);
    check("post sreset hit", dh, 0);
    check("post sreset miss", dm, 0);

    press(4'b1000);
    beat(dh, dm);
    check("again hit", dh, 1);
    check("again score", int'(score), 1);
    check("again pressed", int'(pressed_arrow), 10);

    // rst_n asserted across a beat with a press pending.
    press(4'b1000);
    @(negedge clk);
    rst_n = 1'b0;
    beat(dh, dm);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstbeat hit", dh, 0);
    check("rstbeat miss", dm, 0);
    check("rstbeat score", int'(score), 0);
    check("rstbeat combo", int'(combo_count), 0);
    check("rstbeat pressed", int'(pressed_arrow), 20);
    beat(dh, dm);
    check("after rst hit", dh, 0);
    check("after rst miss", dm, 0);

    check("hit miss overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
